// File: rtl/sig_hint_unpack.sv
// sig_hint_unpack -- byte-serial decoder for the hint section of a packed
// signature (verify path). Consumes OMEGA index bytes followed by K
// cumulative count bytes, rebuilds the K x N hint polynomials (one 32-bit
// word per coefficient, value 0 or 1) and flags malformed encodings.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   start     one-cycle pulse, begins a decode (honoured only when idle)
//   in_data   hint byte, signature byte order
//   in_valid  in_data is valid
//   in_ready  byte accepted when in_valid & in_ready
//   h_out     hint polynomials, coefficient (i,j) at [(i*N+j)*32 +: 32]
//   done      one-cycle pulse when decode finishes
//   err       encoding invalid; valid from done until the next start
module sig_hint_unpack #(
  parameter int K     = 6,
  parameter int N     = 256,
  parameter int OMEGA = 55
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [K*N*32-1:0] h_out,
  output logic              done,
  output logic              err
);

  localparam int              PW        = (K > 1) ? $clog2(K) : 1;
  localparam int              IW        = $clog2(OMEGA);
  localparam int              NW        = $clog2(N);
  localparam logic [7:0]      OMEGA_B   = 8'(OMEGA);
  localparam logic [PW-1:0]   LAST_POLY = PW'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_IDX, S_LOAD_CNT, S_EXPAND, S_TAIL, S_DRAIN, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] poly_q, poly_d;
  logic [7:0]    j_q, j_d;        // index byte counter / expand & tail cursor
  logic [7:0]    prev_q, prev_d;  // cumulative count at the start of poly_q
  logic [7:0]    cnt_q, cnt_d;    // cumulative count of poly_q
  logic          err_q, err_d;

  logic [7:0]    idx_buf_q [OMEGA];
  // Only bit 0 of each output word can ever be set, so keep one flop per
  // coefficient and zero-extend at the port.
  logic [K-1:0][N-1:0] hbits_q;

  logic          idx_wr, h_clr, h_set;
  logic [IW-1:0] j_m1;
  logic [7:0]    idx_cur, idx_prv;
  logic          last_poly;

  assign j_m1      = j_q[IW-1:0] - IW'(1);
  assign idx_cur   = idx_buf_q[j_q[IW-1:0]];
  assign idx_prv   = idx_buf_q[j_m1];
  assign last_poly = (poly_q == LAST_POLY);

  always_comb begin
    state_d  = state_q;
    poly_d   = poly_q;
    j_d      = j_q;
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    idx_wr   = 1'b0;
    h_clr    = 1'b0;
    h_set    = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          h_clr   = 1'b1;
          err_d   = 1'b0;
          j_d     = '0;
          poly_d  = '0;
          prev_d  = '0;
          cnt_d   = '0;
          state_d = S_LOAD_IDX;
        end
      end
      S_LOAD_IDX: begin
        in_ready = 1'b1;
        if (in_valid) begin
          idx_wr = 1'b1;
          if (j_q == OMEGA_B - 8'd1) begin
            j_d     = '0;
            state_d = S_LOAD_CNT;
          end else begin
            j_d = j_q + 8'd1;
          end
        end
      end
      S_LOAD_CNT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_d = in_data;
          if (in_data < prev_q || in_data > OMEGA_B) begin
            err_d = 1'b1;
            // Remaining count bytes must still be swallowed to keep the
            // signature stream aligned.
            if (last_poly) state_d = S_DONE;
            else begin
              poly_d  = poly_q + PW'(1);
              state_d = S_DRAIN;
            end
          end else if (in_data == prev_q) begin
            if (last_poly) begin
              // A full hint list leaves no tail to check.
              if (prev_q == OMEGA_B) state_d = S_DONE;
              else begin
                j_d     = prev_q;
                state_d = S_TAIL;
              end
            end else begin
              poly_d = poly_q + PW'(1);
            end
          end else begin
            j_d     = prev_q;
            state_d = S_EXPAND;
          end
        end
      end
      S_EXPAND: begin
        h_set = 1'b1;
        // Indices within one poly must be strictly increasing; the first
        // index of a poly has no predecessor to compare against.
        if (j_q != prev_q && idx_cur <= idx_prv) begin
          err_d = 1'b1;
          if (last_poly) state_d = S_DONE;
          else begin
            poly_d  = poly_q + PW'(1);
            state_d = S_DRAIN;
          end
        end else if (j_q == cnt_q - 8'd1) begin
          prev_d = cnt_q;
          if (last_poly) begin
            if (cnt_q == OMEGA_B) state_d = S_DONE;
            else begin
              j_d     = cnt_q;
              state_d = S_TAIL;
            end
          end else begin
            poly_d  = poly_q + PW'(1);
            state_d = S_LOAD_CNT;
          end
        end else begin
          j_d = j_q + 8'd1;
        end
      end
      S_TAIL: begin
        // Unused index slots must be zero; every slot is visited.
        if (idx_cur != 8'd0) err_d = 1'b1;
        if (j_q == OMEGA_B - 8'd1) state_d = S_DONE;
        else j_d = j_q + 8'd1;
      end
      S_DRAIN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (last_poly) state_d = S_DONE;
          else poly_d = poly_q + PW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      poly_q  <= '0;
      j_q     <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      hbits_q <= '0;
    end else begin
      state_q <= state_d;
      poly_q  <= poly_d;
      j_q     <= j_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (h_clr)      hbits_q <= '0;
      else if (h_set) hbits_q[poly_q][idx_cur[NW-1:0]] <= 1'b1;
    end
  end

  // Index buffer is always fully rewritten before it is read.
  always_ff @(posedge clk) begin
    if (idx_wr) idx_buf_q[j_q[IW-1:0]] <= in_data;
  end

  assign err = err_q;

  for (genvar gi = 0; gi < K; gi++) begin : g_poly
    for (genvar gj = 0; gj < N; gj++) begin : g_coef
      assign h_out[(gi*N+gj)*32 +: 32] = {31'd0, hbits_q[gi][gj]};
    end
  end

endmodule

// File: tb/tb_sig_hint_unpack.sv
module tb_sig_hint_unpack;
  localparam int K = 6, N = 256, OMEGA = 55, NB = OMEGA + K, HW = K*N*32;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready, done, err;
  logic [HW-1:0] h_out;

  always #5 clk = ~clk;

  sig_hint_unpack #(.K(K), .N(N), .OMEGA(OMEGA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .h_out(h_out),
    .done(done), .err(err)
  );

  typedef struct {
    logic          err;
    int            lat;
    logic [HW-1:0] h;
    bit            chk_h;
  } exp_t;

  exp_t          sb[$];
  int            total = 0, bad = 0;
  logic [7:0]    stim [NB];
  logic [HW-1:0] m_h;
  logic          m_err;

  // Observed results of the last drive
  int            o_lat, o_gaps;
  logic          o_err, o_rdy1;
  logic [HW-1:0] o_h;

  task automatic clear_stim();
    foreach (stim[i]) stim[i] = 8'd0;
  endtask

  task automatic set_counts(input int c0, c1, c2, c3, c4, c5);
    stim[OMEGA+0] = 8'(c0); stim[OMEGA+1] = 8'(c1); stim[OMEGA+2] = 8'(c2);
    stim[OMEGA+3] = 8'(c3); stim[OMEGA+4] = 8'(c4); stim[OMEGA+5] = 8'(c5);
  endtask

  // Behavioural reference decode of stim[] into m_h / m_err.
  task automatic ref_model();
    int  prev, c;
    bit  stop;
    m_h = '0; m_err = 1'b0; prev = 0; stop = 0;
    for (int i = 0; i < K && !stop; i++) begin
      c = int'(stim[OMEGA+i]);
      if (c < prev || c > OMEGA) begin
        m_err = 1'b1; stop = 1;
      end else begin
        for (int j = prev; j < c && !stop; j++) begin
          m_h[(i*N + int'(stim[j]))*32] = 1'b1;
          if (j > prev && stim[j] <= stim[j-1]) begin m_err = 1'b1; stop = 1; end
        end
        prev = c;
      end
    end
    if (!stop)
      for (int j = prev; j < OMEGA; j++) if (stim[j] != 8'd0) m_err = 1'b1;
  endtask

  task automatic push_exp(input int lat);
    exp_t e;
    ref_model();
    e.err = m_err; e.lat = lat; e.h = m_h; e.chk_h = !m_err;
    sb.push_back(e);
  endtask

  function automatic int first_diff(input logic [HW-1:0] a, input logic [HW-1:0] b);
    for (int w = 0; w < K*N; w++) if (a[w*32 +: 32] !== b[w*32 +: 32]) return w;
    return -1;
  endfunction

  // Runs one decode of stim[]. Gap cycles are only inserted before bytes
  // with index < gap_limit, where the decoder is known to be waiting.
  task automatic drive(input int gap_limit, input bit spam);
    int  p, cyc, g;
    bit  acc;
    p = 0; o_gaps = 0; o_lat = -1; o_err = 1'bx; o_h = 'x; o_rdy1 = 1'bx;
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 start = 1'b0; cyc = 1;
    g = (gap_limit > 0) ? int'($urandom_range(0, 2)) : 0;
    while (cyc < 2000) begin
      @(negedge clk);
      if (cyc == 1) o_rdy1 = in_ready;
      if (done) begin
        o_lat = cyc; o_err = err; o_h = h_out;
        break;
      end
      start = spam && (cyc % 7 == 3);
      if (p >= NB) in_valid = 1'b0;
      else if (g > 0) begin in_valid = 1'b0; g--; o_gaps++; end
      else begin in_valid = 1'b1; in_data = stim[p]; end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) begin
        p++;
        g = (p < gap_limit) ? int'($urandom_range(0, 2)) : 0;
      end
      #1 cyc++;
    end
    if (o_lat < 0) $display("FAIL timeout: no done within %0d cycles", cyc);
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic fill_valid_hint();
    clear_stim();
    stim[0] = 8'd3; stim[1] = 8'd17; stim[2] = 8'd200; stim[3] = 8'd5;
    set_counts(3, 3, 4, 4, 4, 4);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++; if (h_out !== '0) begin bad++; $display("FAIL reset_h_out: first nonzero word %0d", first_diff(h_out, '0)); end
  endtask

  task automatic test_all_zero();
    exp_t e;
    clear_stim(); push_exp(117); drive(0, 0); e = sb.pop_front();
    total++; if (o_rdy1 !== 1'b1) begin bad++; $display("FAIL zero_ready_cycle1: got %b want 1", o_rdy1); end
    total++; if (o_lat !== e.lat) begin bad++; $display("FAIL zero_latency: got %0d want %0d", o_lat, e.lat); end
    total++; if (o_err !== e.err) begin bad++; $display("FAIL zero_err: got %b want %b", o_err, e.err); end
    total++; if (o_h !== e.h) begin bad++; $display("FAIL zero_h_out: first bad word %0d", first_diff(o_h, e.h)); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_valid_hint();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) fill_valid_hint();
      else begin
        clear_stim();
        for (int j = 0; j < OMEGA; j++) stim[j] = 8'(j + 1);
        set_counts(55, 55, 55, 55, 55, 55);
      end
      push_exp(117); drive(0, 0); e = sb.pop_front();
      total++; if (o_lat !== e.lat) begin bad++; $display("FAIL valid%0d_latency: got %0d want %0d", c, o_lat, e.lat); end
      total++; if (o_err !== e.err) begin bad++; $display("FAIL valid%0d_err: got %b want %b", c, o_err, e.err); end
      if (e.chk_h) begin
        total++; if (o_h !== e.h) begin bad++; $display("FAIL valid%0d_h_out: first bad word %0d", c, first_diff(o_h, e.h)); end
      end
      if (c == 0) begin
        total++; if (o_h[(0*N+200)*32 +: 32] !== 32'd1) begin bad++; $display("FAIL valid_word_0_200: got %0h want 1", o_h[(0*N+200)*32 +: 32]); end
        total++; if (o_h[(2*N+5)*32 +: 32] !== 32'd1) begin bad++; $display("FAIL valid_word_2_5: got %0h want 1", o_h[(2*N+5)*32 +: 32]); end
      end
    end
  endtask

  task automatic test_non_increasing();
    exp_t e;
    clear_stim(); stim[0] = 8'd17; stim[1] = 8'd17; set_counts(2, 2, 2, 2, 2, 2);
    push_exp(64); drive(0, 0); e = sb.pop_front();
    total++; if (o_lat !== e.lat) begin bad++; $display("FAIL noninc_latency: got %0d want %0d", o_lat, e.lat); end
    total++; if (o_err !== e.err) begin bad++; $display("FAIL noninc_err: got %b want %b", o_err, e.err); end
  endtask

  task automatic test_cnt_range();
    exp_t e;
    int   lat_tab [3] = '{62, 65, 62};
    for (int c = 0; c < 3; c++) begin
      clear_stim();
      case (c)
        0: set_counts(0, 56, 0, 0, 0, 0);
        1: begin stim[0] = 8'd1; stim[1] = 8'd2; stim[2] = 8'd3; set_counts(3, 3, 1, 1, 1, 1); end
        default: set_counts(0, 0, 0, 0, 0, 56);
      endcase
      push_exp(lat_tab[c]); drive(0, 0); e = sb.pop_front();
      total++; if (o_lat !== e.lat) begin bad++; $display("FAIL range%0d_latency: got %0d want %0d", c, o_lat, e.lat); end
      total++; if (o_err !== e.err) begin bad++; $display("FAIL range%0d_err: got %b want %b", c, o_err, e.err); end
    end
  endtask

  task automatic test_tail();
    exp_t e;
    fill_valid_hint(); stim[30] = 8'd9;
    push_exp(117); drive(0, 0); e = sb.pop_front();
    total++; if (o_lat !== e.lat) begin bad++; $display("FAIL tail_latency: got %0d want %0d", o_lat, e.lat); end
    total++; if (o_err !== e.err) begin bad++; $display("FAIL tail_err: got %b want %b", o_err, e.err); end
    repeat (5) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tail_err_held: got %b want 1", err); end
  endtask

  task automatic test_gaps();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin fill_valid_hint(); drive(OMEGA + 1, 0); end
      else begin clear_stim(); drive(NB, 0); end
      push_exp(117 + o_gaps); e = sb.pop_front();
      total++; if (o_lat !== e.lat) begin bad++; $display("FAIL gaps%0d_latency: got %0d want %0d", c, o_lat, e.lat); end
      total++; if (o_err !== e.err) begin bad++; $display("FAIL gaps%0d_err: got %b want %b", c, o_err, e.err); end
      total++; if (o_h !== e.h) begin bad++; $display("FAIL gaps%0d_h_out: first bad word %0d", c, first_diff(o_h, e.h)); end
    end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    fill_valid_hint(); push_exp(117); drive(0, 1); e = sb.pop_front();
    total++; if (o_lat !== e.lat) begin bad++; $display("FAIL spam_latency: got %0d want %0d", o_lat, e.lat); end
    total++; if (o_err !== e.err) begin bad++; $display("FAIL spam_err: got %b want %b", o_err, e.err); end
    total++; if (o_h !== e.h) begin bad++; $display("FAIL spam_h_out: first bad word %0d", first_diff(o_h, e.h)); end
  endtask

  // Expects the previous decode to have been the valid hint section.
  task automatic test_reset_mid();
    exp_t e;
    fill_valid_hint(); ref_model();
    repeat (3) @(negedge clk);
    total++; if (h_out !== m_h) begin bad++; $display("FAIL held_h_out: first bad word %0d", first_diff(h_out, m_h)); end
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    total++; if (h_out !== '0) begin bad++; $display("FAIL idle_reset_h_out: first nonzero word %0d", first_diff(h_out, '0)); end
    // Start a decode and pull reset in cycle 20.
    @(negedge clk); start = 1'b1; in_valid = 1'b1; in_data = 8'd1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL midrst_err: got %b want 0", err); end
    total++; if (h_out !== '0) begin bad++; $display("FAIL midrst_h_out: first nonzero word %0d", first_diff(h_out, '0)); end
    clear_stim(); stim[0] = 8'd7; set_counts(1, 1, 1, 1, 1, 1);
    push_exp(117); drive(0, 0); e = sb.pop_front();
    total++; if (o_lat !== e.lat) begin bad++; $display("FAIL recover_latency: got %0d want %0d", o_lat, e.lat); end
    total++; if (o_err !== e.err) begin bad++; $display("FAIL recover_err: got %b want %b", o_err, e.err); end
    total++; if (o_h !== e.h) begin bad++; $display("FAIL recover_h_out: first bad word %0d", first_diff(o_h, e.h)); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    test_reset();
    test_all_zero();
    test_valid_hint();
    test_non_increasing();
    test_cnt_range();
    test_tail();
    test_gaps();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
